// File: rtl/sha3_pkg.sv
// ----------------------------------------------------------------------------
// sha3_pkg
// Shared Keccak-f[1600] definitions used by the lane serializer slice.
//   LANE_W      : width of one Keccak lane (64 bits)
//   LANE_COUNT  : number of lanes in the full state (25)
//   ROW_LANES   : lanes per row (5)
//   row_t       : one state row, element x holds lane x+5y of row y
//   lane_pos_t  : row/column coordinates of a lane
//   ser_state_t : serializer FSM states
//   lane_pos()  : maps a linear lane index to its row and column
// ----------------------------------------------------------------------------
package sha3_pkg;

    localparam int LANE_W     = 64;
    localparam int LANE_COUNT = 25;
    localparam int ROW_LANES  = 5;

    typedef logic [ROW_LANES-1:0][LANE_W-1:0] row_t;

    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
    } lane_pos_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Lane index i lives at row i/5, column i%5.
    function automatic lane_pos_t lane_pos(input logic [4:0] index);
        lane_pos_t pos;
        pos.row = 3'(index / 5);
        pos.col = 3'(index % 5);
        return pos;
    endfunction

endpackage

// File: rtl/sha3_lane_serializer_if.sv
// ----------------------------------------------------------------------------
// sha3_lane_serializer_if
// Bundles the state input, the producer handshake and the lane output stream
// of the serializer.
//   isa..ise : Keccak state rows y=0..4 (row_t)
//   sample   : producer says the state is valid this cycle
//   obusy    : a sample this cycle would be ignored
//   odata    : current lane, oindex : its lane number, olast : final lane
//   ovalid / iready : output stream handshake
//   odropped : sticky "a sample was ignored" flag
// master = the surroundings (producer + consumer), slave = the serializer.
// ----------------------------------------------------------------------------
interface sha3_lane_serializer_if;
    import sha3_pkg::*;

    row_t              isa;
    row_t              isb;
    row_t              isc;
    row_t              isd;
    row_t              ise;
    logic              sample;
    logic              obusy;
    logic [LANE_W-1:0] odata;
    logic              ovalid;
    logic              iready;
    logic [4:0]        oindex;
    logic              olast;
    logic              odropped;

    modport master (
        output isa, isb, isc, isd, ise, sample, iready,
        input  obusy, odata, ovalid, oindex, olast, odropped
    );

    modport slave (
        input  isa, isb, isc, isd, ise, sample, iready,
        output obusy, odata, ovalid, oindex, olast, odropped
    );

endinterface

// File: rtl/sha3_state_capture.sv
// ----------------------------------------------------------------------------
// sha3_state_capture
// Holds a copy of the full 1600-bit Keccak state.
//   clk, rstn     : clock and synchronous active-low reset (ogood only)
//   isa..ise      : incoming state rows
//   sample        : capture strobe
//   osa..ose      : captured rows (BUFFERIZE=1) or the inputs passed through
//   ogood         : registered copy of sample (or sample itself when bypassed)
// The state registers carry no reset; only the strobe flag does.
// ----------------------------------------------------------------------------
module sha3_state_capture
    import sha3_pkg::*;
#(
    parameter int BUFFERIZE = 1
) (
    input  logic clk,
    input  logic rstn,
    input  row_t isa,
    input  row_t isb,
    input  row_t isc,
    input  row_t isd,
    input  row_t ise,
    input  logic sample,
    output row_t osa,
    output row_t osb,
    output row_t osc,
    output row_t osd,
    output row_t ose,
    output logic ogood
);

    generate
        if (BUFFERIZE != 0) begin : g_buffer
            row_t sa, sb, sc, sd, se;
            logic good;

            always_ff @(posedge clk) begin
                if (sample) begin
                    sa <= isa;
                    sb <= isb;
                    sc <= isc;
                    sd <= isd;
                    se <= ise;
                end
            end

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    good <= 1'b0;
                end else begin
                    good <= sample;
                end
            end

            assign osa   = sa;
            assign osb   = sb;
            assign osc   = sc;
            assign osd   = sd;
            assign ose   = se;
            assign ogood = good;
        end else begin : g_bypass
            assign osa   = isa;
            assign osb   = isb;
            assign osc   = isc;
            assign osd   = isd;
            assign ose   = ise;
            assign ogood = sample;
        end
    endgenerate

endmodule

// File: rtl/sha3_lane_serializer.sv
// ----------------------------------------------------------------------------
// sha3_lane_serializer
// Snapshots a Keccak state and streams its first OUT_LANES lanes, one 64-bit
// lane per beat, over a valid/ready handshake.
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : sha3_lane_serializer_if.slave (state in, sample/obusy, lane stream)
// A new state can be accepted in the same cycle the final lane transfers, so
// consecutive states stream without a bubble. Samples that arrive while busy
// are ignored and latch the sticky odropped flag.
// ----------------------------------------------------------------------------
module sha3_lane_serializer
    import sha3_pkg::*;
#(
    parameter int OUT_LANES = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    sha3_lane_serializer_if.slave   bus
);

    localparam logic [4:0] LAST_INDEX = 5'(OUT_LANES - 1);

    generate
        if (OUT_LANES < 1 || OUT_LANES > LANE_COUNT) begin : g_bad_out_lanes
            $error("sha3_lane_serializer: OUT_LANES must be within 1..25");
        end
    endgenerate

    ser_state_t state_q, state_d;
    logic [4:0] index_q, index_d;
    logic       dropped_q, dropped_d;
    logic       in_send;
    logic       last_beat;
    logic       busy;
    logic       accept;
    row_t       snap_a, snap_b, snap_c, snap_d, snap_e;
    row_t       snap_rows [ROW_LANES];
    lane_pos_t  pos;
    logic       capture_ogood_unused;

    assign in_send   = (state_q == SEND);
    assign last_beat = in_send && (index_q == LAST_INDEX);
    // Busy unless the final lane leaves this very cycle; iready feeds this
    // combinationally so the producer can chain states without a gap.
    assign busy      = in_send && !(last_beat && bus.iready);
    // Gated by rstn so a sample during reset neither captures nor counts.
    assign accept    = bus.sample && !busy && rstn;

    sha3_state_capture #(
        .BUFFERIZE (1)
    ) u_capture (
        .clk    (clk),
        .rstn   (rstn),
        .isa    (bus.isa),
        .isb    (bus.isb),
        .isc    (bus.isc),
        .isd    (bus.isd),
        .ise    (bus.ise),
        .sample (accept),
        .osa    (snap_a),
        .osb    (snap_b),
        .osc    (snap_c),
        .osd    (snap_d),
        .ose    (snap_e),
        .ogood  (capture_ogood_unused)
    );

    assign snap_rows[0] = snap_a;
    assign snap_rows[1] = snap_b;
    assign snap_rows[2] = snap_c;
    assign snap_rows[3] = snap_d;
    assign snap_rows[4] = snap_e;

    // State, lane counter and drop flag registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            index_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            dropped_q <= dropped_d;
        end
    end

    // An accept always restarts at lane 0, which also covers the overlap with
    // the final transfer of the previous state.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        dropped_d = dropped_q;
        if (bus.sample && busy) begin
            dropped_d = 1'b1;
        end
        if (accept) begin
            state_d = SEND;
            index_d = '0;
        end else if (in_send && bus.iready) begin
            if (last_beat) begin
                state_d = IDLE;
                index_d = '0;
            end else begin
                index_d = index_q + 5'd1;
            end
        end
    end

    assign pos          = lane_pos(index_q);
    assign bus.obusy    = busy;
    assign bus.ovalid   = in_send;
    assign bus.oindex   = index_q;
    assign bus.olast    = last_beat;
    assign bus.odropped = dropped_q;
    assign bus.odata    = in_send ? snap_rows[pos.row][pos.col] : '0;

endmodule

// File: tb/tb_sha3_lane_serializer.sv
// ----------------------------------------------------------------------------
// tb_sha3_lane_serializer
// Drives three serializers (OUT_LANES = 4, 1, 25) through a shared stimulus
// path; only the selected one sees samples. Expected lanes are queued when a
// state is sampled and popped as the selected DUT transfers them.
// ----------------------------------------------------------------------------
module tb_sha3_lane_serializer;
    import sha3_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  index;
        logic        last;
    } beat_t;

    typedef struct {
        int          sel;
        logic [63:0] base;
        logic [3:0]  ready_pat;
        int          exp_beats;
        logic        exp_dropped;
    } vector_t;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    int          sel  = 0;
    row_t        rows [5];
    logic        cur_sample = 1'b0;
    logic        cur_iready = 1'b1;
    logic [3:0]  ready_pat  = 4'hf;
    logic [31:0] cyc = '0;

    beat_t       exp_q [$];
    int          beats_seen = 0;
    logic        mon_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [69:0] prev_out = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    sha3_lane_serializer_if bus4 ();
    sha3_lane_serializer_if bus1 ();
    sha3_lane_serializer_if bus25 ();

    sha3_lane_serializer #(.OUT_LANES(4))  dut4  (.clk(clk), .rstn(rstn), .bus(bus4.slave));
    sha3_lane_serializer #(.OUT_LANES(1))  dut1  (.clk(clk), .rstn(rstn), .bus(bus1.slave));
    sha3_lane_serializer #(.OUT_LANES(25)) dut25 (.clk(clk), .rstn(rstn), .bus(bus25.slave));

    assign bus4.isa  = rows[0];  assign bus4.isb  = rows[1];  assign bus4.isc  = rows[2];
    assign bus4.isd  = rows[3];  assign bus4.ise  = rows[4];
    assign bus1.isa  = rows[0];  assign bus1.isb  = rows[1];  assign bus1.isc  = rows[2];
    assign bus1.isd  = rows[3];  assign bus1.ise  = rows[4];
    assign bus25.isa = rows[0];  assign bus25.isb = rows[1];  assign bus25.isc = rows[2];
    assign bus25.isd = rows[3];  assign bus25.ise = rows[4];

    assign bus4.sample  = (sel == 0) ? cur_sample : 1'b0;
    assign bus1.sample  = (sel == 1) ? cur_sample : 1'b0;
    assign bus25.sample = (sel == 2) ? cur_sample : 1'b0;
    assign bus4.iready  = (sel == 0) ? cur_iready : 1'b1;
    assign bus1.iready  = (sel == 1) ? cur_iready : 1'b1;
    assign bus25.iready = (sel == 2) ? cur_iready : 1'b1;

    logic        m_valid, m_busy, m_last, m_dropped;
    logic [63:0] m_data;
    logic [4:0]  m_index;

    // Outputs of whichever DUT is currently selected.
    always_comb begin
        case (sel)
            0: begin
                m_valid = bus4.ovalid;  m_busy = bus4.obusy;  m_last = bus4.olast;
                m_dropped = bus4.odropped;  m_data = bus4.odata;  m_index = bus4.oindex;
            end
            1: begin
                m_valid = bus1.ovalid;  m_busy = bus1.obusy;  m_last = bus1.olast;
                m_dropped = bus1.odropped;  m_data = bus1.odata;  m_index = bus1.oindex;
            end
            default: begin
                m_valid = bus25.ovalid;  m_busy = bus25.obusy;  m_last = bus25.olast;
                m_dropped = bus25.odropped;  m_data = bus25.odata;  m_index = bus25.oindex;
            end
        endcase
    end

    function automatic int lanes_of(input int s);
        return (s == 0) ? 4 : ((s == 1) ? 1 : 25);
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; iready follows the
    // current 4-cycle ready pattern.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        cur_iready = ready_pat[cyc[1:0]];
    endtask

    // Loads lane k = base + k into the state and pulses sample for one edge.
    task automatic applyStimulus(input logic [63:0] base, input logic expect_accept);
        int n;
        n = lanes_of(sel);
        for (int k = 0; k < 25; k++) rows[k / 5][k % 5] = base + 64'(k);
        cur_sample = 1'b1;
        if (expect_accept) begin
            for (int k = 0; k < n; k++)
                exp_q.push_back('{data: base + 64'(k), index: 5'(k), last: (k == n - 1)});
        end
        tick();
        cur_sample = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || m_valid) && guard < 400) begin
            tick();
            guard++;
        end
        if (guard >= 400) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: got %0d lanes pending, expected 0", exp_q.size());
        end
        tick();
        tick();
    endtask

    // Scoreboard: every transfer must match the head of the queue, stalled
    // lanes must hold, and idle cycles must show zero data and olast.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall)
                checkOutput("stall_hold", {m_valid, m_data, m_index, m_last}, {1'b1, prev_out});
            if (m_valid && cur_iready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_beat: got lane %0d data %h, expected no beat",
                             m_index, m_data);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    checkOutput("beat", {m_data, m_index, m_last}, {e.data, e.index, e.last});
                    beats_seen++;
                end
            end else if (!m_valid) begin
                checkOutput("idle_zero", {m_data, m_last}, '0);
            end
            prev_stall = m_valid && !cur_iready;
            prev_out   = {m_data, m_index, m_last};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vector_t vec [6];
        vec[0] = '{sel: 0, base: 64'h1000, ready_pat: 4'b1111, exp_beats: 4,  exp_dropped: 1'b0};
        vec[1] = '{sel: 0, base: 64'h3000, ready_pat: 4'b1001, exp_beats: 4,  exp_dropped: 1'b0};
        vec[2] = '{sel: 1, base: 64'h4000, ready_pat: 4'b1111, exp_beats: 1,  exp_dropped: 1'b0};
        vec[3] = '{sel: 1, base: 64'h4100, ready_pat: 4'b0101, exp_beats: 1,  exp_dropped: 1'b0};
        vec[4] = '{sel: 2, base: 64'h5000, ready_pat: 4'b1111, exp_beats: 25, exp_dropped: 1'b0};
        vec[5] = '{sel: 2, base: 64'h6000, ready_pat: 4'b1011, exp_beats: 25, exp_dropped: 1'b0};

        for (int r = 0; r < 5; r++) rows[r] = '0;
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkOutput("reset_state", {m_valid, m_data, m_index, m_last, m_dropped, m_busy}, '0);
        end
        sel = 0;
        tick();
        mon_en = 1'b1;

        // Table of single-state transfers across lane counts and ready patterns.
        for (int v = 0; v < 6; v++) begin
            sel        = vec[v].sel;
            ready_pat  = vec[v].ready_pat;
            cur_iready = ready_pat[cyc[1:0]];
            beats_seen = 0;
            applyStimulus(vec[v].base, 1'b1);
            checkOutput("first_beat", {m_valid, m_index, m_data}, {1'b1, 5'd0, vec[v].base});
            drain();
            checkOutput("beat_count", 128'(beats_seen), 128'(vec[v].exp_beats));
            checkOutput("dropped_flag", m_dropped, vec[v].exp_dropped);
        end

        // Back-to-back: second state sampled during the final transfer.
        sel        = 0;
        ready_pat  = 4'hf;
        cur_iready = 1'b1;
        beats_seen = 0;
        applyStimulus(64'h1000, 1'b1);
        repeat (3) tick();
        checkOutput("b2b_on_last", {m_last, m_index, m_data}, {1'b1, 5'd3, 64'h1003});
        cur_iready = 1'b0;
        #1;
        checkOutput("busy_stalled_last", m_busy, 1'b1);
        cur_iready = 1'b1;
        #1;
        checkOutput("busy_free_last", m_busy, 1'b0);
        applyStimulus(64'h2000, 1'b1);
        checkOutput("b2b_no_bubble", {m_valid, m_index, m_data}, {1'b1, 5'd0, 64'h2000});
        drain();
        checkOutput("b2b_beats", 128'(beats_seen), 128'd8);
        checkOutput("b2b_no_drop", m_dropped, 1'b0);

        // Drop: sample while lane 1 is on the bus.
        beats_seen = 0;
        applyStimulus(64'h7000, 1'b1);
        tick();
        checkOutput("drop_busy", m_busy, 1'b1);
        applyStimulus(64'h9000, 1'b0);
        checkOutput("drop_flag_set", m_dropped, 1'b1);
        drain();
        checkOutput("drop_beats", 128'(beats_seen), 128'd4);
        checkOutput("drop_sticky", m_dropped, 1'b1);

        // Reset mid-stream, with a sample in the reset cycle.
        applyStimulus(64'h8000, 1'b1);
        tick();
        mon_en     = 1'b0;
        rstn       = 1'b0;
        cur_sample = 1'b1;
        tick();
        rstn       = 1'b1;
        cur_sample = 1'b0;
        checkOutput("rst_mid", {m_valid, m_index, m_dropped, m_data, m_last}, '0);
        tick();
        checkOutput("rst_sample_ignored", {m_valid, m_dropped}, 2'b00);
        exp_q.delete();
        mon_en     = 1'b1;
        beats_seen = 0;
        applyStimulus(64'hA000, 1'b1);
        checkOutput("rst_restart", {m_valid, m_index, m_data}, {1'b1, 5'd0, 64'hA000});
        drain();
        checkOutput("rst_restart_beats", 128'(beats_seen), 128'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha3_lane_serializer.md
SHA3_LANE_SERIALIZER -- requirements
Module: sha3_lane_serializer

Interface
REQ-001 The block SHALL have parameter OUT_LANES, default 4, giving the number of 64-bit lanes emitted per state; legal range 1..25.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have ports isa, isb, isc, isd, ise, input, 64 bits x 5 each: Keccak state rows y=0..4, where element x is lane x+5y.
REQ-005 The block SHALL have port sample, input, 1 bit: the state on isa..ise is valid this cycle; this is the producer's ogood.
REQ-006 The block SHALL have port obusy, output, 1 bit: high when a sample in this cycle will not be accepted.
REQ-007 The block SHALL have port odata, output, 64 bits: the current lane.
REQ-008 The block SHALL have port ovalid, output, 1 bit: odata is valid.
REQ-009 The block SHALL have port iready, input, 1 bit: the consumer accepts odata; a transfer occurs when ovalid and iready are both high.
REQ-010 The block SHALL have port oindex, output, 5 bits: the lane number (x+5y) of odata.
REQ-011 The block SHALL have port olast, output, 1 bit: high with the lane where oindex equals OUT_LANES-1.
REQ-012 The block SHALL have port odropped, output, 1 bit: sticky flag, set when a sample is ignored.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE and SEND.
REQ-014 An accept SHALL occur when sample is high and either the state is IDLE or the final lane transfers this cycle (SEND, olast high, iready high).
REQ-015 On accept, the block SHALL snapshot all 1600 state bits, set oindex to 0 and enter SEND on the next edge.
REQ-016 Latency SHALL be one cycle: sample high at edge N gives ovalid high with lane 0 from edge N+1.
REQ-017 In SEND, ovalid SHALL be 1 and odata SHALL equal the snapshot lane selected by oindex (row oindex/5, column oindex%5).
REQ-018 On a transfer with olast low, oindex SHALL increment by 1.
REQ-019 On a transfer with olast high and no accept in the same cycle, the FSM SHALL return to IDLE and oindex SHALL become 0.
REQ-020 On a transfer with olast high and an accept in the same cycle, the FSM SHALL stay in SEND with oindex 0 and the new snapshot, leaving no bubble.
REQ-021 When iready is low in SEND, odata, oindex and olast SHALL hold stable and ovalid SHALL stay high.
REQ-022 obusy SHALL equal (state==SEND) AND NOT (olast AND iready); this is a combinational path from iready.
REQ-023 A sample arriving while obusy is high SHALL be ignored, SHALL leave the snapshot unchanged and SHALL set odropped.
REQ-024 odropped SHALL remain set until reset.
REQ-025 When ovalid is 0, odata SHALL be 0 and olast SHALL be 0.
REQ-026 Lanes with index at or above OUT_LANES SHALL never be emitted.
REQ-027 When OUT_LANES is 1, olast SHALL be high on every valid beat.
REQ-028 oindex SHALL never exceed OUT_LANES-1.

Reset
REQ-029 With rstn low at a rising edge, the state SHALL become IDLE, oindex 0 and odropped 0; ovalid, olast and odata therefore read 0.
REQ-030 The snapshot storage SHALL not require reset.
REQ-031 Reset asserted mid-SEND SHALL abort the current state with no further beats; a sample in the reset cycle SHALL be ignored and SHALL not set odropped.

Structure
REQ-032 Shared package sha3_pkg SHALL hold the lane width (64), the lane count (25), the row typedef (64 bits x 5) and a lane-index helper that maps index to row and column.
REQ-033 The snapshot SHALL be one sub-module, sha3_state_capture with BUFFERIZE=1, with its sample input driven by the internal accept; its ogood SHALL be unused.
REQ-034 The FSM, lane counter, lane mux and flag SHALL be local to this block.
REQ-035 An elaboration-time check SHALL reject OUT_LANES outside 1..25.

Verification
REQ-036 Basic: lane k = 64'h1000+k, one sample, iready held high, OUT_LANES=4 -> beats on cycles N+1..N+4 with odata 1000,1001,1002,1003, oindex 0..3, olast only on the 4th beat, then ovalid 0.
REQ-037 Backpressure: iready toggled 1,0,0,1,... -> each lane held stable while stalled, no lane lost or duplicated, order preserved.
REQ-038 Back-to-back: second state (lane k = 64'h2000+k) sampled in the cycle of the first state's olast transfer -> beats 1003 then 2000 on consecutive cycles, odropped stays 0.
REQ-039 Drop: sample during beat 2 of a state -> odropped=1, output sequence unchanged, obusy was high in that cycle.
REQ-040 Reset mid-stream: rstn low after beat 1 -> next cycle ovalid 0, oindex 0, odropped 0; a fresh sample restarts at lane 0.
REQ-041 Parameter sweep: OUT_LANES=1 and OUT_LANES=25 -> 1 and 25 beats respectively, with lane 24 taken from ise[4] and olast correct.
